// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// State encoding and timeout defaults live here so every unit agrees.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// Serve-cycle counter; hit_o flags the last allowed serve cycle.
// Counts from 0 on the first serve cycle, so hit occurs on cycle LIMIT.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// All port-side and requester-side outputs are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              sel,
  output logic              err
);

  arb_state_e state_q, state_d;

  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel_q, sel_d;
  logic              last_data_q, last_data_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic serving;
  logic hit;
  logic gnt_i;
  logic gnt_d;
  logic finish;

  assign serving = (state_q != IDLE);

  arb_wait_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear_i (!serving),
    .en_i    (serving),
    .hit_o   (hit)
  );

  // Fetch wins a tie unless it was the last one served.
  assign gnt_i  = i_req && (!d_req || last_data_q);
  assign gnt_d  = d_req && !gnt_i;
  assign finish = mem_ready || hit;

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    last_data_d = last_data_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_i) begin
          state_d = SERVE_I;
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = i_addr;
          sel_d   = 1'b1;
        end else if (gnt_d) begin
          state_d = SERVE_D;
          en_d    = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          sel_d   = 1'b0;
        end
      end
      SERVE_I: begin
        if (finish) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          we_d        = 1'b0;
          last_data_d = 1'b0;
          i_done_d    = 1'b1;
          err_d       = !mem_ready;
          i_rdata_d   = mem_ready ? mem_rdata : '0;
        end
      end
      SERVE_D: begin
        if (finish) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          we_d        = 1'b0;
          last_data_d = 1'b1;
          d_done_d    = 1'b1;
          err_d       = !mem_ready;
          d_rdata_d   = mem_ready ? mem_rdata : '0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 1'b1;
      last_data_q <= 1'b1;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      last_data_q <= last_data_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign sel       = sel_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small memory model.
// Completions are popped from an expectation queue as done pulses appear.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        sel;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .sel       (sel),
    .err       (err)
  );

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: ready on serve cycle rdy_at (0 = never).
  int          rdy_at    = 0;
  int          serve_cnt = 0;
  logic        force_rdy = 1'b0;
  logic        use_fixed = 1'b0;
  logic [15:0] rd_fixed  = 16'h0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) serve_cnt++;
      else serve_cnt = 0;
      mem_ready = force_rdy ||
        (mem_en === 1'b1 && rdy_at != 0 && serve_cnt == rdy_at);
      mem_rdata = use_fixed ? rd_fixed : mem_f(mem_addr);
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_done === 1'b1 || d_done === 1'b1) begin
        chk("done_exclusive", {31'b0, i_done & d_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_port", {31'b0, d_done}, {31'b0, e.is_d});
          chk("sb_err", {31'b0, err}, {31'b0, e.err});
          chk("sb_rdata", {16'b0, d_done ? d_rdata : i_rdata},
              {16'b0, e.rdata});
        end
      end
    end
  end

  task automatic push(input logic is_d, input logic e, input logic [15:0] r);
    exp_t x;
    x.is_d  = is_d;
    x.err   = e;
    x.rdata = r;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the done of one port, dropping its request on that cycle.
  task automatic run_xact(input logic is_d, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!((is_d ? d_done : i_done) === 1'b1) && lat < 60);
    chk("done_seen", {31'b0, is_d ? d_done : i_done}, 32'd1);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  int lat;
  int ev_cyc[3];
  logic ev_d[3];
  int n_ev;
  int cyc;
  int n_done;

  initial begin
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = 16'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 16'h0;
    d_wdata = 16'h0;
    repeat (3) step();
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_sel", {31'b0, sel}, 32'd1);
    chk("rst_dones", {30'b0, i_done, d_done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    rst = 1'b0;
    step();

    // Fetch with ready on the 2nd serve cycle.
    rdy_at = 2; use_fixed = 1'b1; rd_fixed = 16'hBEEF;
    push(1'b0, 1'b0, 16'hBEEF);
    i_addr = 16'h0040; i_req = 1'b1;
    step();
    chk("f_mem_en", {31'b0, mem_en}, 32'd1);
    chk("f_sel", {31'b0, sel}, 32'd1);
    chk("f_mem_addr", {16'b0, mem_addr}, 32'h40);
    chk("f_mem_we", {31'b0, mem_we}, 32'd0);
    run_xact(1'b0, lat);
    chk("f_lat", lat, 32'd2);
    chk("f_rdata", {16'b0, i_rdata}, 32'hBEEF);
    chk("f_err", {31'b0, err}, 32'd0);
    step();
    chk("f_pulse", {31'b0, i_done}, 32'd0);
    chk("f_idle_en", {31'b0, mem_en}, 32'd0);
    chk("f_hold_sel", {31'b0, sel}, 32'd1);
    chk("f_hold_rdata", {16'b0, i_rdata}, 32'hBEEF);

    // Minimum latency.
    rdy_at = 1; use_fixed = 1'b0;
    i_addr = 16'h0102;
    push(1'b0, 1'b0, mem_f(16'h0102));
    i_req = 1'b1;
    run_xact(1'b0, lat);
    chk("min_lat", lat, 32'd2);
    step();

    // Data store; inputs change after grant but port must hold.
    rdy_at = 4;
    d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'h00AA;
    push(1'b1, 1'b0, mem_f(16'h1234));
    d_req = 1'b1;
    step();
    d_addr = 16'hFFFF; d_wdata = 16'hFFFF; d_we = 1'b0;
    lat = 1;
    while (!(d_done === 1'b1) && lat < 60) begin
      chk("st_en", {31'b0, mem_en}, 32'd1);
      chk("st_we", {31'b0, mem_we}, 32'd1);
      chk("st_addr", {16'b0, mem_addr}, 32'h1234);
      chk("st_wdata", {16'b0, mem_wdata}, 32'h00AA);
      chk("st_sel", {31'b0, sel}, 32'd0);
      step();
      lat++;
    end
    d_req = 1'b0;
    chk("st_lat", lat, 32'd5);
    step();
    chk("st_hold_sel", {31'b0, sel}, 32'd0);

    // Timeout abort on a data load.
    rdy_at = 0;
    d_we = 1'b0; d_addr = 16'h0300;
    push(1'b1, 1'b1, 16'h0);
    d_req = 1'b1;
    run_xact(1'b1, lat);
    chk("to_lat", lat, 32'd16);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_rdata", {16'b0, d_rdata}, 32'd0);
    chk("to_idle", {31'b0, mem_en}, 32'd0);
    step();
    chk("to_err_pulse", {31'b0, err}, 32'd0);

    // Ready on the timeout-hit cycle wins.
    rdy_at = 15; use_fixed = 1'b1; rd_fixed = 16'h5555;
    i_addr = 16'h0500;
    push(1'b0, 1'b0, 16'h5555);
    i_req = 1'b1;
    run_xact(1'b0, lat);
    chk("race_lat", lat, 32'd16);
    chk("race_err", {31'b0, err}, 32'd0);
    chk("race_rdata", {16'b0, i_rdata}, 32'h5555);
    step();

    // Requester drops req mid-transaction.
    rdy_at = 3; use_fixed = 1'b0;
    i_addr = 16'h0777;
    push(1'b0, 1'b0, mem_f(16'h0777));
    i_req = 1'b1;
    step();
    i_req = 1'b0;
    run_xact(1'b0, lat);
    chk("drop_lat", lat, 32'd3);
    step();

    // Ready while idle is ignored.
    force_rdy = 1'b1;
    n_done = 0;
    repeat (3) begin
      step();
      if (i_done === 1'b1 || d_done === 1'b1) n_done++;
      chk("idle_rdy_en", {31'b0, mem_en}, 32'd0);
    end
    chk("idle_rdy_done", n_done, 32'd0);
    force_rdy = 1'b0;
    step();

    // Reset during SERVE_D abandons the transaction.
    rdy_at = 0;
    d_addr = 16'h0900;
    d_req = 1'b1;
    repeat (3) step();
    chk("rs_serving", {31'b0, sel, mem_en}, 32'd1);
    rst = 1'b1;
    step();
    chk("rs_en", {31'b0, mem_en}, 32'd0);
    chk("rs_sel", {31'b0, sel}, 32'd1);
    chk("rs_done", {31'b0, d_done}, 32'd0);
    chk("rs_rdata", {16'b0, i_rdata}, 32'd0);
    rst = 1'b0;
    d_req = 1'b0;
    n_done = 0;
    repeat (20) begin
      step();
      if (i_done === 1'b1 || d_done === 1'b1) n_done++;
    end
    chk("rs_no_done", n_done, 32'd0);

    // Round-robin with both requests held after reset.
    do_reset();
    rdy_at = 1;
    i_addr = 16'h0010; d_addr = 16'h0020; d_we = 1'b0;
    push(1'b0, 1'b0, mem_f(16'h0010));
    push(1'b1, 1'b0, mem_f(16'h0020));
    push(1'b0, 1'b0, mem_f(16'h0010));
    for (int k = 0; k < 3; k++) begin
      ev_cyc[k] = 0;
      ev_d[k]   = 1'b0;
    end
    n_ev = 0; cyc = 0;
    i_req = 1'b1; d_req = 1'b1;
    while (n_ev < 3 && cyc < 60) begin
      step();
      cyc++;
      if (i_done === 1'b1 || d_done === 1'b1) begin
        ev_cyc[n_ev] = cyc;
        ev_d[n_ev]   = d_done;
        chk("rr_bubble", {31'b0, mem_en}, 32'd0);
        n_ev++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("rr_count", n_ev, 32'd3);
    chk("rr_order", {29'b0, ev_d[0], ev_d[1], ev_d[2]}, 32'b010);
    chk("rr_cyc0", ev_cyc[0], 32'd2);
    chk("rr_cyc1", ev_cyc[1], 32'd4);
    chk("rr_cyc2", ev_cyc[2], 32'd6);

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address width.
REQ-002 SHALL have parameter DATA_W, default 16: data width.
REQ-003 SHALL have parameter TIMEOUT, default 15: max cycles in a serve state before abort; legal range 1..255.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_req, input, 1: fetch request, level, held until i_done.
REQ-008 SHALL have port i_addr, input, ADDR_W: fetch address.
REQ-009 SHALL have ports i_rdata (output, DATA_W: fetched word) and i_done (output, 1: one-cycle completion pulse).
REQ-010 SHALL have port d_req, input, 1: data request, level, held until d_done.
REQ-011 SHALL have port d_we, input, 1: data write enable.
REQ-012 SHALL have ports d_addr (input, ADDR_W) and d_wdata (input, DATA_W): data address and write data.
REQ-013 SHALL have ports d_rdata (output, DATA_W: load data) and d_done (output, 1: completion pulse).
REQ-014 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): shared memory port.
REQ-015 SHALL have ports mem_rdata (input, DATA_W) and mem_ready (input, 1: memory completes this cycle).
REQ-016 SHALL have port sel, output, 1: port-mux select, 1 = fetch owns port, 0 = data.
REQ-017 SHALL have port err, output, 1: timeout abort, valid with done pulse.

Function
REQ-018 SHALL implement a state machine with states IDLE, SERVE_I and SERVE_D.
REQ-019 In IDLE with exactly one request, SHALL enter the matching serve state next cycle.
REQ-020 In IDLE with both requests, SHALL grant the requester not served last (round-robin); last_d flag =1 after reset, so fetch wins first.
REQ-021 On grant, SHALL register addr/we/wdata into mem_* outputs; they hold constant for the whole serve state.
REQ-022 SHALL drive mem_en=1 throughout any serve state and 0 in IDLE; mem_we=0 in SERVE_I.
REQ-023 SHALL drive sel=1 in SERVE_I, sel=0 in SERVE_D, and in IDLE hold the last value.
REQ-024 mem_ready sampled high in a serve state at cycle M SHALL produce done=1, rdata=mem_rdata (registered) at M+1, state IDLE at M+1.
REQ-025 Minimum latency SHALL be req seen at N -> serve at N+1 -> done at N+2 when mem_ready at N+1.
REQ-026 Back-to-back transactions SHALL have exactly one IDLE bubble cycle between done and next serve.
REQ-027 done SHALL be a single-cycle pulse; a req still high on the done cycle SHALL be evaluated as a new request in that IDLE cycle.
REQ-028 Dropping req mid-transaction SHALL be ignored; transaction completes and done still pulses.
REQ-029 mem_ready in IDLE SHALL be ignored.
REQ-030 A wait counter SHALL count serve cycles; on reaching TIMEOUT without mem_ready, SHALL return to IDLE, pulse done with err=1, rdata=0.
REQ-031 mem_ready on the same cycle the counter hits TIMEOUT SHALL win: normal completion, err=0.
REQ-032 i_rdata/d_rdata SHALL hold last value until next completion for that requester.
REQ-033 last_d SHALL update only on completion (normal or abort).

Reset
REQ-034 rst SHALL force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, sel=1, i_done=d_done=0, err=0, i_rdata=d_rdata=0, counter=0, last_d=1.
REQ-035 rst mid-transaction SHALL abandon it with no done pulse.

Structure
REQ-036 State encoding (IDLE=2'b00, SERVE_I=2'b01, SERVE_D=2'b10) and TIMEOUT default SHALL live in shared package mem_arb_pkg.
REQ-037 Wait counter SHALL be a separate sub-module arb_wait_counter (clear, enable, hit output).

Verification
REQ-038 Fetch-only: i_req=1, i_addr=0x0040, mem_ready at 2nd serve cycle, mem_rdata=0xBEEF -> i_rdata=0xBEEF, i_done one pulse, sel=1.
REQ-039 Simultaneous i_req and d_req held after reset -> grant order fetch, data, fetch, with one IDLE cycle between each.
REQ-040 Data store: d_we=1, d_addr=0x1234, d_wdata=0x00AA -> mem_we=1, mem_addr=0x1234, mem_wdata=0x00AA stable until mem_ready; d_done pulses.
REQ-041 No mem_ready, TIMEOUT=15 -> d_done and err high at serve cycle 16, d_rdata=0, state IDLE.
REQ-042 rst asserted during SERVE_D -> next cycle mem_en=0, sel=1, no d_done.
REQ-043 mem_ready on the TIMEOUT-hit cycle with mem_rdata=0x5555 -> done with err=0, rdata=0x5555.
